svga_timing: RTL and testbench
==============================

SVGA_TIMING -- requirements
Module: svga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC, H_BACK, defaults 40, 128, 88, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT, V_SYNC, V_BACK, defaults 1, 4, 23, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters H_POL and V_POL, default 1 each, sync active level (1 = active-high).
REQ-006 SHALL have parameters X_SHIFT and Y_SHIFT, default 0 each, right-shift applied to the coordinate outputs.
REQ-007 SHALL have parameter FRAME_W, default 8, frame counter width.
REQ-008 SHALL define H_TOTAL as the sum of the four H parameters, V_TOTAL as the sum of the four V parameters, HW = $clog2(H_TOTAL) and VW = $clog2(V_TOTAL).
REQ-009 Port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-010 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-011 Port en_i, input, 1: pixel enable; counters advance only in cycles where it is high.
REQ-012 Port restart_i, input, 1: synchronous restart to the start of a frame.
REQ-013 Port hsync_o, output, 1: horizontal sync.
REQ-014 Port vsync_o, output, 1: vertical sync.
REQ-015 Port active_o, output, 1: current pixel is visible.
REQ-016 Port x_o, output, HW: hc >> X_SHIFT.
REQ-017 Port y_o, output, VW: vc >> Y_SHIFT.
REQ-018 Port next_vertical_o, output, 1: one-cycle pulse when the line ends.
REQ-019 Port next_frame_o, output, 1: one-cycle pulse when the frame ends.
REQ-020 Port frame_o, output, FRAME_W: count of completed frames.

Function
REQ-021 SHALL keep registers hc (HW bits), vc (VW bits) and frame_o; all other outputs SHALL be decoded combinationally from them, with zero added latency.
REQ-022 When en_i=1 and restart_i=0, hc SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-023 On an hc wrap, vc SHALL increment; at V_TOTAL-1 it SHALL wrap to 0.
REQ-024 On a vc wrap, frame_o SHALL increment, wrapping modulo 2^FRAME_W.
REQ-025 When en_i=0, hc, vc and frame_o SHALL hold, and both pulse outputs SHALL be 0.
REQ-026 When restart_i=1, the next edge SHALL set hc=0 and vc=0 regardless of en_i, and frame_o SHALL hold; restart_i SHALL take priority over en_i.
REQ-027 When restart_i=1, next_vertical_o and next_frame_o SHALL be 0.
REQ-028 active_o SHALL be 1 exactly when hc < H_ACTIVE and vc < V_ACTIVE.
REQ-029 hsync_o SHALL equal H_POL when H_ACTIVE+H_FRONT <= hc < H_ACTIVE+H_FRONT+H_SYNC, and ~H_POL otherwise.
REQ-030 vsync_o SHALL equal V_POL when V_ACTIVE+V_FRONT <= vc < V_ACTIVE+V_FRONT+V_SYNC, and ~V_POL otherwise; it SHALL change only together with a vc change.
REQ-031 next_vertical_o SHALL be 1 when en_i=1, restart_i=0 and hc=H_TOTAL-1.
REQ-032 next_frame_o SHALL be 1 when next_vertical_o=1 and vc=V_TOTAL-1; when it is 1, next_vertical_o SHALL also be 1.
REQ-033 x_o and y_o SHALL be driven in all regions, including blanking; consumers SHALL qualify them with active_o.
REQ-034 Counter comparisons SHALL be unsigned at full counter width; no counter SHALL ever reach H_TOTAL or V_TOTAL.

Reset
REQ-035 While rst_ni=0, the block SHALL hold hc=0, vc=0 and frame_o=0 immediately, with no clock required.
REQ-036 While rst_ni=0, the outputs SHALL be hsync_o=~H_POL, vsync_o=~V_POL, active_o=1, x_o=0, y_o=0, next_vertical_o=0 and next_frame_o=0.
REQ-037 After rst_ni rises, the first enabled edge SHALL advance hc to 1.
REQ-038 Reset asserted mid-line or mid-frame SHALL discard all position and frame state.

Verification
Benches use H=8/2/3/1 (H_TOTAL=14), V=4/1/2/1 (V_TOTAL=8), H_POL=0, V_POL=1, FRAME_W=4 unless stated.
REQ-039 Reset, then en_i=1 constantly -> hsync_o=0 for hc 10..12; next_vertical_o high at cycles 13, 27, ...; active_o high for hc 0..7 on lines 0..3.
REQ-040 Run 112 enabled cycles -> vsync_o=1 on lines 5..6; next_frame_o single pulse at cycle 111; frame_o goes 0->1 and hc=vc=0 afterwards.
REQ-041 Toggle en_i 1/0 alternately -> counters advance every other cycle; no pulse while en_i=0; line length becomes 28 clocks.
REQ-042 Assert restart_i with en_i=1 at hc=5, vc=2 -> next cycle hc=0, vc=0, frame_o unchanged, no pulses.
REQ-043 Run 16 full frames -> frame_o wraps from 15 to 0.
REQ-044 Assert rst_ni low mid-frame (hc=9, vc=6) between clock edges -> outputs take their REQ-036 values immediately; X_SHIFT=1 variant shows x_o = hc/2.

Source files
------------

// File: rtl/svga_timing.sv
// ---------------------------------------------------------------------------
// svga_timing
//
// Raster timing generator for a VGA/SVGA style display. A horizontal pixel
// counter (hc), a vertical line counter (vc) and a frame counter are the
// only state. Every other output is decoded combinationally from that state
// (and from en_i/restart_i for the end-of-line/frame pulses), so it changes
// on the same clock edge as the counters, with no added latency.
//
// Line layout (hc):  [ active | front porch | sync | back porch ]
// Frame layout (vc): [ active | front porch | sync | back porch ]
//
// There are no handshakes here. en_i is a pixel-rate qualifier: a cycle
// with en_i=1 is one pixel time, and a cycle with en_i=0 is idle.
//
// Ports
//   clk_i            : clock; all state changes on its rising edge
//   rst_ni           : asynchronous active-low reset
//   en_i             : pixel enable; counters advance only when high
//   restart_i        : synchronous return to hc=0, vc=0 (frame count held);
//                      wins over en_i
//   hsync_o          : horizontal sync, active level H_POL
//   vsync_o          : vertical sync, active level V_POL
//   active_o         : current pixel lies inside the visible area
//   x_o              : hc >> X_SHIFT (driven in blanking too)
//   y_o              : vc >> Y_SHIFT (driven in blanking too)
//   next_vertical_o  : high in the enabled cycle that ends a line
//   next_frame_o     : high in the enabled cycle that ends a frame
//   frame_o          : completed-frame count, wraps modulo 2^FRAME_W
// ---------------------------------------------------------------------------
module svga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int X_SHIFT  = 0,
  parameter int Y_SHIFT  = 0,
  parameter int FRAME_W  = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               restart_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               active_o,
  output logic [HW-1:0]      x_o,
  output logic [VW-1:0]      y_o,
  output logic               next_vertical_o,
  output logic               next_frame_o,
  output logic [FRAME_W-1:0] frame_o
);

  // Region boundaries are held one bit wider than the counters. The end of
  // the sync window can equal H_TOTAL (zero back porch), which may be
  // exactly 2^HW and would not fit in HW bits.
  localparam logic [HW:0] H_LAST_C       = (HW+1)'(H_TOTAL - 1);
  localparam logic [HW:0] H_ACTIVE_C     = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] H_SYNC_START_C = (HW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [HW:0] H_SYNC_END_C   = (HW+1)'(H_ACTIVE + H_FRONT + H_SYNC);

  localparam logic [VW:0] V_LAST_C       = (VW+1)'(V_TOTAL - 1);
  localparam logic [VW:0] V_ACTIVE_C     = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] V_SYNC_START_C = (VW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [VW:0] V_SYNC_END_C   = (VW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0]      hc_q, hc_d;
  logic [VW-1:0]      vc_q, vc_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // Zero-extended counters for unsigned full-width comparisons.
  logic [HW:0] hc_ext;
  logic [VW:0] vc_ext;

  logic at_line_end;   // hc is on the last pixel of the line
  logic at_frame_end;  // vc is on the last line of the frame
  logic step;          // this cycle advances the raster position

  assign hc_ext = {1'b0, hc_q};
  assign vc_ext = {1'b0, vc_q};

  assign at_line_end  = (hc_ext == H_LAST_C);
  assign at_frame_end = (vc_ext == V_LAST_C);
  assign step         = en_i & ~restart_i;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    frame_d = frame_q;

    if (restart_i) begin
      // Restart rewinds the raster but keeps the frame count, so a consumer
      // counting frames is not disturbed by a resync.
      hc_d = '0;
      vc_d = '0;
    end else if (en_i) begin
      if (at_line_end) begin
        hc_d = '0;
        if (at_frame_end) begin
          vc_d    = '0;
          frame_d = frame_q + 1'b1;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      frame_q <= frame_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    active_o = (hc_ext < H_ACTIVE_C) && (vc_ext < V_ACTIVE_C);

    hsync_o = ~H_POL;
    if ((hc_ext >= H_SYNC_START_C) && (hc_ext < H_SYNC_END_C)) begin
      hsync_o = H_POL;
    end

    // Depends on vc only, so it can change only when vc changes.
    vsync_o = ~V_POL;
    if ((vc_ext >= V_SYNC_START_C) && (vc_ext < V_SYNC_END_C)) begin
      vsync_o = V_POL;
    end

    // The pulses fall out of step, so they are quiet when idle or
    // restarting, and next_frame_o always implies next_vertical_o.
    next_vertical_o = step & at_line_end;
    next_frame_o    = step & at_line_end & at_frame_end;
  end

  assign x_o     = hc_q >> X_SHIFT;
  assign y_o     = vc_q >> Y_SHIFT;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_svga_timing.sv
// ---------------------------------------------------------------------------
// tb_svga_timing
//
// Directed bench for svga_timing with a 14x8 raster
// (H 8/2/3/1, V 4/1/2/1, H_POL=0, V_POL=1, FRAME_W=4).
// Two instances share all inputs: dut (no coordinate shift) is used to
// observe hc/vc directly, dut_s has X_SHIFT=1.
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge (or mid-cycle for the asynchronous reset checks).
// ---------------------------------------------------------------------------
module tb_svga_timing;

  localparam int HT = 14;
  localparam int VT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en;
  logic restart;

  logic       hs, vs, act, nv, nf;
  logic [3:0] x;
  logic [2:0] y;
  logic [3:0] fr;

  logic       hs_s, vs_s, act_s, nv_s, nf_s;
  logic [3:0] x_s;
  logic [2:0] y_s;
  logic [3:0] fr_s;

  svga_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b0), .V_POL(1'b1), .X_SHIFT(0), .Y_SHIFT(0), .FRAME_W(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .restart_i(restart),
    .hsync_o(hs), .vsync_o(vs), .active_o(act), .x_o(x), .y_o(y),
    .next_vertical_o(nv), .next_frame_o(nf), .frame_o(fr)
  );

  svga_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b0), .V_POL(1'b1), .X_SHIFT(1), .Y_SHIFT(0), .FRAME_W(4)
  ) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .restart_i(restart),
    .hsync_o(hs_s), .vsync_o(vs_s), .active_o(act_s), .x_o(x_s), .y_o(y_s),
    .next_vertical_o(nv_s), .next_frame_o(nf_s), .frame_o(fr_s)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check_vals(input string tag, input int e_hc, input int e_vc,
                            input int e_fr, input bit e_hs, input bit e_vs,
                            input bit e_act, input bit e_nv, input bit e_nf);
    check({tag, ".hc"},     int'(x),   e_hc);
    check({tag, ".vc"},     int'(y),   e_vc);
    check({tag, ".frame"},  int'(fr),  e_fr);
    check({tag, ".hsync"},  int'(hs),  int'(e_hs));
    check({tag, ".vsync"},  int'(vs),  int'(e_vs));
    check({tag, ".active"}, int'(act), int'(e_act));
    check({tag, ".nv"},     int'(nv),  int'(e_nv));
    check({tag, ".nf"},     int'(nf),  int'(e_nf));
    check({tag, ".x_s"},    int'(x_s), e_hc / 2);
  endtask

  // Expected outputs from the raster definition for a given position.
  task automatic check_state(input string tag, input int e_hc, input int e_vc,
                             input int e_fr, input bit en_v, input bit rs_v);
    bit e_hs, e_vs, e_act, e_nv, e_nf;
    e_hs  = !(e_hc >= 10 && e_hc < 13);
    e_vs  = (e_vc >= 5 && e_vc < 7);
    e_act = (e_hc < 8) && (e_vc < 4);
    e_nv  = en_v && !rs_v && (e_hc == HT - 1);
    e_nf  = e_nv && (e_vc == VT - 1);
    check_vals(tag, e_hc, e_vc, e_fr, e_hs, e_vs, e_act, e_nv, e_nf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_en(input int n);
    en      = 1'b1;
    restart = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_restart();
    en      = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int pre;        // enabled edges run before applying the vector
    bit en;
    bit rs;
    int hc, vc, fr;
    bit hs, vs, act, nv, nf;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  // Watchdog: every wait is on the clock, but never let the run hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int first_pulse;
    int last_pulse;
    int f_exp;

    //                pre en rs hc vc fr hs vs act nv nf
    vecs[0]  = '{ 0, 1'b0, 1'b0,  0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{ 0, 1'b1, 1'b0,  0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{12, 1'b1, 1'b0, 13, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{13, 1'b0, 1'b0, 13, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{ 6, 1'b1, 1'b1,  5, 2, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{ 0, 1'b1, 1'b0,  0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{12, 1'b1, 1'b1, 13, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{ 3, 1'b0, 1'b1,  3, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{ 0, 1'b0, 1'b0,  0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{10, 1'b1, 1'b0, 10, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{ 1, 1'b1, 1'b0, 12, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{57, 1'b1, 1'b0,  0, 5, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{40, 1'b1, 1'b0, 13, 7, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{ 0, 1'b1, 1'b0,  0, 0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{83, 1'b1, 1'b0,  0, 6, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{13, 1'b0, 1'b0,  0, 7, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // ---- reset, checked before any clock edge ----
    rst_n   = 1'b1;
    en      = 1'b1;
    restart = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_vals("reset0", 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    check_vals("reset_held", 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    en    = 1'b1;
    rst_n = 1'b1;

    // ---- one full frame with en held high ----
    for (int c = 0; c < HT * VT; c++) begin
      @(negedge clk);
      check_state($sformatf("frame_c%0d", c), c % HT, c / HT, 0, 1'b1, 1'b0);
      tick();
    end
    @(negedge clk);
    check_state("after_frame", 0, 0, 1, 1'b1, 1'b0);
    tick();
    do_restart();

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      run_en(vecs[i].pre);
      en      = vecs[i].en;
      restart = vecs[i].rs;
      @(negedge clk);
      check_vals($sformatf("v%0d", i), vecs[i].hc, vecs[i].vc, vecs[i].fr,
                 vecs[i].hs, vecs[i].vs, vecs[i].act, vecs[i].nv, vecs[i].nf);
      tick();
    end

    // ---- en toggling 1/0: line takes 28 clocks, no pulse while idle ----
    do_restart();
    pulses      = 0;
    first_pulse = -1;
    last_pulse  = -1;
    for (int k = 0; k < 56; k++) begin
      en      = (k % 2 == 0);
      restart = 1'b0;
      @(negedge clk);
      check($sformatf("toggle_hc_k%0d", k), int'(x), ((k + 1) / 2) % HT);
      check($sformatf("toggle_vc_k%0d", k), int'(y), ((k + 1) / 2) / HT);
      check($sformatf("toggle_nv_k%0d", k), int'(nv),
            int'((k % 2 == 0) && (((k + 1) / 2) % HT == HT - 1)));
      if (nv) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
        last_pulse = k;
      end
      tick();
    end
    check("toggle_pulse_count", pulses, 2);
    check("toggle_line_clocks", last_pulse - first_pulse, 28);

    // ---- 16 frames: frame counter passes 15 -> 0 ----
    do_restart();
    f_exp = 2;
    for (int f = 1; f <= 16; f++) begin
      run_en(HT * VT);
      check($sformatf("wrap_frame_%0d", f), int'(fr), (f_exp + f) % 16);
      check($sformatf("wrap_pos_%0d", f), int'({y, x}), 0);
    end

    // ---- asynchronous reset mid-frame at hc=9, vc=6 ----
    do_restart();
    run_en(6 * HT + 9);
    #2;
    check_state("pre_rst", 9, 6, 2, 1'b1, 1'b0);
    check("pre_rst.y_s", int'(y_s), 6);
    rst_n = 1'b0;
    #1;
    check_vals("async_rst", 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("async_rst.y_s", int'(y_s), 0);
    tick();
    check_vals("rst_hold", 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    check_state("first_edge", 1, 0, 0, 1'b1, 1'b0);
    run_en(2);
    check_state("shift_x3", 3, 0, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
